// File: rtl/piano_key_renderer.sv
// Multi-octave VGA piano keyboard renderer with polyphonic PS/2 key lighting.
// Pixel geometry is tracked incrementally per column; colour arrives 2 clocks after iCol/iRow.
module piano_key_renderer #(
  parameter int NUM_OCTAVES = 2,
  parameter int X0          = 40,
  parameter int Y0          = 100,
  parameter int KEY_H       = 280,
  parameter int BLACK_H     = 140,
  parameter int WHITE_W     = 40,
  parameter int BLACK_W     = 24,
  parameter int HOLD_FRAMES = 6
) (
  input  logic                        Clock,
  input  logic                        Reset,
  input  logic [31:0]                 iCol,
  input  logic [31:0]                 iRow,
  input  logic                        iFrameStart,
  input  logic [7:0]                  iScancode,
  input  logic                        iScanValid,
  output logic                        oVGA_R,
  output logic                        oVGA_G,
  output logic                        oVGA_B,
  output logic [12*NUM_OCTAVES-1:0]   oKeysLit,
  output logic [1:0]                  oOctave
);

  localparam int KEYS   = 12 * NUM_OCTAVES;
  localparam int WHITES = 7 * NUM_OCTAVES;
  localparam int X1     = X0 + WHITES * WHITE_W;
  localparam int Y1     = Y0 + KEY_H;
  localparam int YB     = Y0 + BLACK_H;
  localparam int HW     = (HOLD_FRAMES > 0) ? $clog2(HOLD_FRAMES + 1) : 1;
  localparam int PW     = $clog2(WHITE_W);

  localparam logic [2:0] C_BLACK  = 3'b000;
  localparam logic [2:0] C_BLUE   = 3'b001;
  localparam logic [2:0] C_RED    = 3'b100;
  localparam logic [2:0] C_YELLOW = 3'b110;
  localparam logic [2:0] C_WHITE  = 3'b111;

  function automatic logic [3:0] whiteNote(input logic [2:0] m);
    case (m)
      3'd0:    return 4'd0;
      3'd1:    return 4'd2;
      3'd2:    return 4'd4;
      3'd3:    return 4'd5;
      3'd4:    return 4'd7;
      3'd5:    return 4'd9;
      default: return 4'd11;
    endcase
  endfunction

  function automatic logic [5:0] octBase(input logic [1:0] o);
    case (o)
      2'd0:    return 6'd0;
      2'd1:    return 6'd12;
      2'd2:    return 6'd24;
      default: return 6'd36;
    endcase
  endfunction

  // ---------------- scancode FSM ----------------
  typedef enum logic {IDLE = 1'b0, BREAK = 1'b1} scanState_t;

  scanState_t state, stateNext;
  logic       doMake, doBreak;
  logic       isE0, isF0;

  assign isE0 = (iScancode == 8'hE0);
  assign isF0 = (iScancode == 8'hF0);

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) state <= IDLE;
    else        state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    if (iScanValid && !isE0) begin
      case (state)
        IDLE:    if (isF0) stateNext = BREAK;
        default: stateNext = IDLE;
      endcase
    end
  end

  always_comb begin
    doMake  = 1'b0;
    doBreak = 1'b0;
    if (iScanValid && !isE0) begin
      case (state)
        IDLE:    doMake  = !isF0;
        default: doBreak = 1'b1;
      endcase
    end
  end

  // ---------------- note decode ----------------
  logic       noteHit;
  logic [3:0] noteOff;
  logic [5:0] keySel;

  always_comb begin
    noteHit = 1'b1;
    noteOff = 4'd0;
    case (iScancode)
      8'h1A:   noteOff = 4'd0;
      8'h1B:   noteOff = 4'd1;
      8'h22:   noteOff = 4'd2;
      8'h23:   noteOff = 4'd3;
      8'h21:   noteOff = 4'd4;
      8'h2A:   noteOff = 4'd5;
      8'h34:   noteOff = 4'd6;
      8'h32:   noteOff = 4'd7;
      8'h33:   noteOff = 4'd8;
      8'h31:   noteOff = 4'd9;
      8'h3B:   noteOff = 4'd10;
      8'h3A:   noteOff = 4'd11;
      default: noteHit = 1'b0;
    endcase
  end

  assign keySel = octBase(oOctave) + {2'b00, noteOff};

  // ---------------- key state ----------------
  logic [KEYS-1:0] pressed, pressedNext, litNext;
  logic [HW-1:0]   hold     [KEYS];
  logic [HW-1:0]   holdNext [KEYS];
  logic [1:0]      octNext;

  always_comb begin
    pressedNext = pressed;
    for (int k = 0; k < KEYS; k++) begin
      holdNext[k] = hold[k];
      if (iFrameStart && hold[k] != '0)
        holdNext[k] = hold[k] - 1'b1;
      // a release landing on a frame pulse reloads rather than decrements
      if (noteHit && keySel == 6'(k)) begin
        if (doMake) pressedNext[k] = 1'b1;
        if (doBreak) begin
          pressedNext[k] = 1'b0;
          holdNext[k]    = HW'(HOLD_FRAMES);
        end
      end
      litNext[k] = pressedNext[k] | (holdNext[k] != '0);
    end
  end

  always_comb begin
    octNext = oOctave;
    if (doMake && iScancode == 8'h55 && oOctave != 2'(NUM_OCTAVES - 1))
      octNext = oOctave + 2'd1;
    if (doMake && iScancode == 8'h4E && oOctave != 2'd0)
      octNext = oOctave - 2'd1;
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      pressed  <= '0;
      oKeysLit <= '0;
      oOctave  <= 2'd0;
      for (int k = 0; k < KEYS; k++) hold[k] <= '0;
    end else begin
      pressed  <= pressedNext;
      oKeysLit <= litNext;
      oOctave  <= octNext;
      for (int k = 0; k < KEYS; k++) hold[k] <= holdNext[k];
    end
  end

  // ---------------- pixel stage 1 ----------------
  logic [PW-1:0] wPos, curPos;
  logic [4:0]    wIdx, curIdx;
  logic [2:0]    wMod, curMod, prevMod;
  logic [1:0]    wOct, curOct, leftOct;
  logic          inBox, upper, rightBlk, leftBlk;
  logic [5:0]    keyNext;

  always_comb begin
    curPos = wPos + 1'b1;
    curIdx = wIdx;
    curMod = wMod;
    curOct = wOct;
    if (iCol == 32'(X0)) begin
      curPos = '0;
      curIdx = '0;
      curMod = '0;
      curOct = '0;
    end else if (wPos == PW'(WHITE_W - 1)) begin
      curPos = '0;
      curIdx = wIdx + 5'd1;
      if (wMod == 3'd6) begin
        curMod = 3'd0;
        curOct = wOct + 2'd1;
      end else begin
        curMod = wMod + 3'd1;
      end
    end
  end

  assign prevMod = (curMod == 3'd0) ? 3'd6 : curMod - 3'd1;
  assign leftOct = (curMod == 3'd0) ? curOct - 2'd1 : curOct;

  assign inBox = (iCol >= 32'(X0)) && (iCol < 32'(X1)) &&
                 (iRow >= 32'(Y0)) && (iRow < 32'(Y1));
  assign upper = iRow < 32'(YB);

  // E and B have no sharp, so no black key follows mod-7 slots 2 and 6
  assign rightBlk = (curPos >= PW'(WHITE_W - BLACK_W / 2)) &&
                    (curMod != 3'd2) && (curMod != 3'd6);
  assign leftBlk  = (curPos < PW'(BLACK_W / 2)) && (curIdx != 5'd0) &&
                    (prevMod != 3'd2) && (prevMod != 3'd6);

  always_comb begin
    unique case (1'b1)
      upper && rightBlk:
        keyNext = octBase(curOct) + {2'b00, whiteNote(curMod)} + 6'd1;
      upper && leftBlk:
        keyNext = octBase(leftOct) + {2'b00, whiteNote(prevMod)} + 6'd1;
      default:
        keyNext = octBase(curOct) + {2'b00, whiteNote(curMod)};
    endcase
  end

  logic       s1Border, s1Black, s1Sep;
  logic [5:0] s1Key;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      wPos     <= '0;
      wIdx     <= '0;
      wMod     <= '0;
      wOct     <= '0;
      s1Border <= 1'b0;
      s1Black  <= 1'b0;
      s1Sep    <= 1'b0;
      s1Key    <= '0;
    end else begin
      wPos     <= curPos;
      wIdx     <= curIdx;
      wMod     <= curMod;
      wOct     <= curOct;
      s1Border <= !inBox;
      s1Black  <= upper && (rightBlk || leftBlk);
      s1Sep    <= (curPos == '0);
      s1Key    <= keyNext;
    end
  end

  // ---------------- pixel stage 2 ----------------
  logic [63:0] litPad;
  logic        lit;
  logic [2:0]  pixNext;

  assign litPad = {{(64 - KEYS){1'b0}}, oKeysLit};
  assign lit    = litPad[s1Key];

  always_comb begin
    if (s1Border)     pixNext = C_BLUE;
    else if (s1Black) pixNext = lit ? C_RED : C_BLACK;
    else if (s1Sep)   pixNext = C_BLACK;
    else              pixNext = lit ? C_YELLOW : C_WHITE;
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) {oVGA_R, oVGA_G, oVGA_B} <= 3'b000;
    else        {oVGA_R, oVGA_G, oVGA_B} <= pixNext;
  end

endmodule
